// File: rtl/blocked_ram_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : blocked_ram_pkg
//  Description : Shared constants for the blocked_ram_sdp_init block RAM:
//                sweep FSM state encoding, byte-lane width and a clog2
//                helper that never returns less than 1.
//  Revision    : 1.0 - initial release
// ============================================================================
package blocked_ram_pkg;

    // Clear-sweep FSM encoding
    localparam logic [0:0] ST_INIT  = 1'b0;
    localparam logic [0:0] ST_READY = 1'b1;

    // Width of one byte lane controlled by a single byte enable
    localparam int c_BYTE_W = 8;

    // Address width for a given depth; at least 1 so a depth-1 RAM still has a port
    function automatic int clog2_min1(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/blocked_ram_sdp_core.sv
`default_nettype none
// ============================================================================
//  Module      : blocked_ram_sdp_core
//  Description : Raw simple-dual-port storage array with byte-enable writes
//                and a registered, read-first read port. Deliberately has no
//                reset so that synthesis maps it onto block RAM.
//  Revision    : 1.0 - initial release
// ============================================================================
module blocked_ram_sdp_core
    import blocked_ram_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 64,
    parameter int AW     = 6,
    localparam int BW    = DATA_W / c_BYTE_W
)(
    input  logic              clk,
    input  logic              i_we,
    input  logic [AW-1:0]     i_waddr,
    input  logic [BW-1:0]     i_wbe,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_re,
    input  logic [AW-1:0]     i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;

    // Byte-lane write: only lanes with their enable set are updated
    always_ff @(posedge clk) begin
        if (i_we) begin
            for (int i = 0; i < BW; i++) begin
                if (i_wbe[i]) begin
                    r_mem[i_waddr][i*c_BYTE_W +: c_BYTE_W] <= i_wdata[i*c_BYTE_W +: c_BYTE_W];
                end
            end
        end
    end

    // Registered read; a same-address write in the same cycle is not visible (read-first)
    always_ff @(posedge clk) begin
        if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/blocked_ram_sdp_init.sv
`default_nettype none
// ============================================================================
//  Module      : blocked_ram_sdp_init
//  Description : Simple-dual-port block RAM with per-byte write enables,
//                selectable read-during-write behaviour, a read-valid flag
//                and a hardware clear sweep after every reset. Ports are
//                ignored until the sweep has zeroed the whole array.
//                Optional macro BRAM_OUT_REG_EN adds an output register
//                (read latency 2 instead of 1).
//  Revision    : 1.0 - initial release
// ============================================================================
module blocked_ram_sdp_init
    import blocked_ram_pkg::*;
#(
    parameter int BRAM_WIDTH = 32,
    parameter int BRAM_DEPTH = 64,
    parameter int RDW_MODE   = 0,
    localparam int AW        = clog2_min1(BRAM_DEPTH),
    localparam int BW        = BRAM_WIDTH / c_BYTE_W
)(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [AW-1:0]         wr_addr,
    input  logic [BW-1:0]         wr_be,
    input  logic [BRAM_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [AW-1:0]         rd_addr,
    output logic [BRAM_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  init_done
);

    localparam logic [AW:0]   c_DEPTH   = (AW+1)'(BRAM_DEPTH);
    localparam logic [AW-1:0] c_LAST    = AW'(BRAM_DEPTH - 1);
    localparam logic          c_RDW_NEW = (RDW_MODE == 1);

    // Sweep FSM
    logic [0:0]    r_state;
    logic [AW-1:0] r_sweep_cnt;
    logic          r_init_done;

    // Port qualification
    logic w_ready;
    logic w_wr_in_range;
    logic w_rd_in_range;
    logic w_wr_acc;
    logic w_rd_acc;
    logic w_core_re;
    logic w_collide;

    // Core array interface
    logic                  w_core_we;
    logic [AW-1:0]         w_core_waddr;
    logic [BW-1:0]         w_core_wbe;
    logic [BRAM_WIDTH-1:0] w_core_wdata;
    logic [BRAM_WIDTH-1:0] w_core_rdata;

    // Context of the most recent accepted read, kept alongside the array output
    logic                  r_rd_valid1;
    logic                  r_rd_have;
    logic                  r_rd_oor;
    logic                  r_rd_byp;
    logic [BRAM_WIDTH-1:0] r_byp_data;
    logic [BW-1:0]         r_byp_be;
    logic [BRAM_WIDTH-1:0] w_merged;
    logic [BRAM_WIDTH-1:0] w_rd_word;

    assign w_ready       = (r_state == ST_READY);
    assign w_wr_in_range = ({1'b0, wr_addr} < c_DEPTH);
    assign w_rd_in_range = ({1'b0, rd_addr} < c_DEPTH);
    assign w_wr_acc      = w_ready & wr_en & w_wr_in_range;
    assign w_rd_acc      = w_ready & rd_en;
    assign w_core_re     = w_rd_acc & w_rd_in_range;
    assign w_collide     = w_wr_acc & w_core_re & (wr_addr == rd_addr);

    // While sweeping, the array write port belongs to the clear counter
    assign w_core_we    = ~w_ready | w_wr_acc;
    assign w_core_waddr = w_ready ? wr_addr : r_sweep_cnt;
    assign w_core_wbe   = w_ready ? wr_be   : {BW{1'b1}};
    assign w_core_wdata = w_ready ? wr_data : {BRAM_WIDTH{1'b0}};

    blocked_ram_sdp_core #(
        .DATA_W (BRAM_WIDTH),
        .DEPTH  (BRAM_DEPTH),
        .AW     (AW)
    ) u_core (
        .clk     (clk),
        .i_we    (w_core_we),
        .i_waddr (w_core_waddr),
        .i_wbe   (w_core_wbe),
        .i_wdata (w_core_wdata),
        .i_re    (w_core_re),
        .i_raddr (rd_addr),
        .o_rdata (w_core_rdata)
    );

    // Clear sweep: one zero write per cycle, then READY until the next reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_INIT;
            r_sweep_cnt <= '0;
            r_init_done <= 1'b0;
        end else begin
            case (r_state)
                ST_INIT: begin
                    if (r_sweep_cnt == c_LAST) begin
                        r_state     <= ST_READY;
                        r_init_done <= 1'b1;
                    end else begin
                        r_sweep_cnt <= r_sweep_cnt + 1'b1;
                    end
                end
                ST_READY: begin
                    r_state <= ST_READY;
                end
                default: begin
                    r_state <= ST_INIT;
                end
            endcase
        end
    end

    assign init_done = r_init_done;

    // Capture read context only on accepted reads so the output holds between reads
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_valid1 <= 1'b0;
            r_rd_have   <= 1'b0;
            r_rd_oor    <= 1'b0;
            r_rd_byp    <= 1'b0;
            r_byp_data  <= '0;
            r_byp_be    <= '0;
        end else begin
            r_rd_valid1 <= w_rd_acc;
            if (w_rd_acc) begin
                r_rd_have  <= 1'b1;
                r_rd_oor   <= ~w_rd_in_range;
                r_rd_byp   <= c_RDW_NEW & w_collide;
                r_byp_data <= wr_data;
                r_byp_be   <= wr_be;
            end
        end
    end

    // New-data read-during-write: overlay the written lanes onto the old array word
    always_comb begin
        w_merged = w_core_rdata;
        for (int i = 0; i < BW; i++) begin
            if (r_byp_be[i]) begin
                w_merged[i*c_BYTE_W +: c_BYTE_W] = r_byp_data[i*c_BYTE_W +: c_BYTE_W];
            end
        end
    end

    // Zero until the first read after reset, and for out-of-range reads
    assign w_rd_word = (~r_rd_have | r_rd_oor) ? {BRAM_WIDTH{1'b0}}
                     : (r_rd_byp ? w_merged : w_core_rdata);

`ifdef BRAM_OUT_REG_EN
    logic                  r_rd_valid2;
    logic [BRAM_WIDTH-1:0] r_rd_out;

    // Extra output stage; loads only when the first stage carries a read result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_valid2 <= 1'b0;
            r_rd_out    <= '0;
        end else begin
            r_rd_valid2 <= r_rd_valid1;
            if (r_rd_valid1) begin
                r_rd_out <= w_rd_word;
            end
        end
    end

    assign rd_data  = r_rd_out;
    assign rd_valid = r_rd_valid2;
`else
    assign rd_data  = w_rd_word;
    assign rd_valid = r_rd_valid1;
`endif

endmodule
`default_nettype wire

// File: tb/tb_blocked_ram_sdp_init.sv
`default_nettype none
// ============================================================================
//  Module      : tb_blocked_ram_sdp_init
//  Description : Self-checking bench for blocked_ram_sdp_init. Two instances
//                share one stimulus stream: depth 64 / old-data RDW and
//                depth 48 / new-data RDW. A behavioural array model predicts
//                every output after every clock edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_blocked_ram_sdp_init;

`ifdef BRAM_OUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic        clk     = 1'b0;
    logic        rst     = 1'b0;
    logic        wr_en   = 1'b0;
    logic [5:0]  wr_addr = '0;
    logic [3:0]  wr_be   = '0;
    logic [31:0] wr_data = '0;
    logic        rd_en   = 1'b0;
    logic [5:0]  rd_addr = '0;

    logic [31:0] rd_data0, rd_data1;
    logic        rd_valid0, rd_valid1;
    logic        init_done0, init_done1;

    always #5 clk = ~clk;

    blocked_ram_sdp_init #(.BRAM_WIDTH(32), .BRAM_DEPTH(64), .RDW_MODE(0)) u_dut0 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be),
        .wr_data(wr_data), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data0), .rd_valid(rd_valid0), .init_done(init_done0)
    );

    blocked_ram_sdp_init #(.BRAM_WIDTH(32), .BRAM_DEPTH(48), .RDW_MODE(1)) u_dut1 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be),
        .wr_data(wr_data), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data1), .rd_valid(rd_valid1), .init_done(init_done1)
    );

    // Reference model state
    int          depth_m [2] = '{64, 48};
    int          mode_m  [2] = '{0, 1};
    logic [31:0] mem_m   [2][64];
    logic        hv      [2][2];
    logic [31:0] hd      [2][2];
    logic        exp_valid [2];
    logic [31:0] exp_data  [2];
    logic        exp_done  [2];
    int          cyc;

    int err_cnt = 0;
    int chk_cnt = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) r[i*8 +: 8] = nw[i*8 +: 8];
        end
        return r;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int a = 0; a < 64; a++) mem_m[k][a] = '0;
            hv[k][0] = 1'b0; hv[k][1] = 1'b0;
            hd[k][0] = '0;   hd[k][1] = '0;
            exp_valid[k] = 1'b0;
            exp_data[k]  = '0;
            exp_done[k]  = 1'b0;
        end
        cyc = 0;
    endtask

    // Predict the effect of one clock edge: ports count only once the array
    // has been cleared (depth edges after reset release)
    task automatic model_edge(input logic we, input logic [5:0] wa, input logic [3:0] be,
                              input logic [31:0] wd, input logic re, input logic [5:0] ra);
        logic        ready;
        logic        v;
        logic [31:0] d;
        for (int k = 0; k < 2; k++) begin
            ready = (cyc >= depth_m[k]);
            v     = ready && re;
            d     = '0;
            if (v && int'(ra) < depth_m[k]) begin
                d = mem_m[k][ra];
                if (mode_m[k] == 1 && we && wa == ra) d = merge(d, wd, be);
            end
            if (ready && we && int'(wa) < depth_m[k]) mem_m[k][wa] = merge(mem_m[k][wa], wd, be);
            hv[k][1] = hv[k][0]; hd[k][1] = hd[k][0];
            hv[k][0] = v;        hd[k][0] = d;
            exp_valid[k] = hv[k][LAT-1];
            if (exp_valid[k]) exp_data[k] = hd[k][LAT-1];
            exp_done[k] = (cyc + 1 >= depth_m[k]);
        end
        cyc++;
    endtask

    task automatic check_outputs();
        check_val("rd_valid0",  {31'b0, rd_valid0},  {31'b0, exp_valid[0]});
        check_val("rd_data0",   rd_data0,            exp_data[0]);
        check_val("init_done0", {31'b0, init_done0}, {31'b0, exp_done[0]});
        check_val("rd_valid1",  {31'b0, rd_valid1},  {31'b0, exp_valid[1]});
        check_val("rd_data1",   rd_data1,            exp_data[1]);
        check_val("init_done1", {31'b0, init_done1}, {31'b0, exp_done[1]});
    endtask

    // Drive one cycle from the falling edge, check just after the rising edge
    task automatic step(input logic we, input logic [5:0] wa, input logic [3:0] be,
                        input logic [31:0] wd, input logic re, input logic [5:0] ra);
        wr_en = we; wr_addr = wa; wr_be = be; wr_data = wd;
        rd_en = re; rd_addr = ra;
        model_edge(we, wa, be, wd, re, ra);
        @(posedge clk);
        #1;
        check_outputs();
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 6'd0, 4'h0, 32'h0, 1'b0, 6'd0);
    endtask

    // Asynchronous reset between clock edges; outputs must clear at once
    task automatic reset_pulse();
        #2;
        rst   = 1'b1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        #1;
        check_val("rst_rd_data0",   rd_data0,            32'h0);
        check_val("rst_rd_valid0",  {31'b0, rd_valid0},  32'h0);
        check_val("rst_init_done0", {31'b0, init_done0}, 32'h0);
        check_val("rst_rd_data1",   rd_data1,            32'h0);
        check_val("rst_rd_valid1",  {31'b0, rd_valid1},  32'h0);
        check_val("rst_init_done1", {31'b0, init_done1}, 32'h0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0]  wa;
        logic [5:0]  ra;
        logic [3:0]  be;
        logic [31:0] wd;
        logic        we;
        logic        re;

        model_reset();
        @(negedge clk);
        reset_pulse();

        // Sweep period with a write and a read that must be dropped
        idle(10);
        step(1'b1, 6'd5, 4'hF, 32'hDEADBEEF, 1'b0, 6'd0);
        step(1'b0, 6'd0, 4'h0, 32'h0, 1'b1, 6'd5);
        idle(54);

        // Every word reads zero after the sweep
        for (int a = 0; a < 64; a++) step(1'b0, 6'd0, 4'h0, 32'h0, 1'b1, 6'(a));
        idle(2);

        // Byte enables
        step(1'b1, 6'd3, 4'hF, 32'h11223344, 1'b0, 6'd0);
        step(1'b1, 6'd3, 4'h5, 32'hAABBCCDD, 1'b0, 6'd0);
        step(1'b0, 6'd0, 4'h0, 32'h0, 1'b1, 6'd3);
        idle(1);
        check_val("be_merge0", rd_data0, 32'h11BB33DD);
        check_val("be_merge1", rd_data1, 32'h11BB33DD);

        // Same-address read during write
        step(1'b1, 6'd7, 4'hF, 32'h0000FFFF, 1'b0, 6'd0);
        step(1'b1, 6'd7, 4'hF, 32'h12345678, 1'b1, 6'd7);
        idle(1);
        check_val("rdw_old0", rd_data0, 32'h0000FFFF);
        check_val("rdw_new1", rd_data1, 32'h12345678);

        // Range boundary on the depth-48 instance
        step(1'b1, 6'd50, 4'hF, 32'hCAFEF00D, 1'b0, 6'd0);
        step(1'b0, 6'd0, 4'h0, 32'h0, 1'b1, 6'd50);
        idle(1);
        check_val("oor_rd1", rd_data1, 32'h0);
        step(1'b1, 6'd47, 4'hF, 32'h47474747, 1'b0, 6'd0);
        step(1'b0, 6'd0, 4'h0, 32'h0, 1'b1, 6'd47);
        idle(1);
        check_val("last_rd1", rd_data1, 32'h47474747);

        // Random traffic, biased toward collisions
        for (int n = 0; n < 300; n++) begin
            we = 1'($urandom_range(1));
            re = 1'($urandom_range(1));
            wa = 6'($urandom_range(63));
            ra = ($urandom_range(3) == 0) ? wa : 6'($urandom_range(63));
            be = 4'($urandom_range(15));
            wd = $urandom;
            step(we, wa, be, wd, re, ra);
        end
        idle(2);

        // Reset while a read is in flight
        step(1'b1, 6'd9, 4'hF, 32'h99999999, 1'b0, 6'd0);
        step(1'b0, 6'd0, 4'h0, 32'h0, 1'b1, 6'd9);
        reset_pulse();

        // Reset in the middle of the sweep, then everything reads zero again
        idle(20);
        reset_pulse();
        idle(65);
        for (int a = 0; a < 64; a++) step(1'b0, 6'd0, 4'h0, 32'h0, 1'b1, 6'(a));
        idle(2);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
`default_nettype wire
